// File: rtl/alu_word_sequencer_pkg.sv
// ============================================================================
// alu_word_sequencer_pkg : ALU mode codes, flag bit indices and helpers for
//                          the 16-bit INCW/DECW word sequencer.
// Revision 1.0
// ============================================================================
`default_nettype none

package alu_word_sequencer_pkg;

   localparam int BYTE_W = 8;
   localparam int MODE_W = 5;

   // Mode codes shared with the ALU
   localparam logic [MODE_W-1:0] ALU1_NOP          = 5'd0;
   localparam logic [MODE_W-1:0] ALU1_INCW         = 5'd12;
   localparam logic [MODE_W-1:0] ALU1_DECW         = 5'd13;
   localparam logic [MODE_W-1:0] ALU1_INCW_UPPER_0 = 5'd14;

   // Flag byte layout
   localparam int FLAG_INDEX_C = 0;
   localparam int FLAG_INDEX_D = 1;
   localparam int FLAG_INDEX_V = 2;
   localparam int FLAG_INDEX_H = 4;
   localparam int FLAG_INDEX_Z = 6;
   localparam int FLAG_INDEX_S = 7;

   // Upper-byte pass only propagates the carry/borrow out of the low byte.
   function automatic logic [MODE_W-1:0] upper_mode(input logic              is_dec,
                                                     input logic [BYTE_W-1:0] lo_res);
      if (is_dec)
         return (lo_res == 8'hFF) ? ALU1_DECW : ALU1_INCW_UPPER_0;
      return (lo_res == 8'h00) ? ALU1_INCW : ALU1_INCW_UPPER_0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_word_sequencer.sv
// ============================================================================
// alu_word_sequencer : sequences a byte-wise INCW/DECW over a register pair,
//                      driving an external ALU and register file.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_word_sequencer
   import alu_word_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op_dec,
   input  logic [BYTE_W-1:0] pair_addr,
   input  logic [BYTE_W-1:0] flags_in,
   output logic              busy,
   output logic              done,
   output logic [BYTE_W-1:0] rf_addr,
   input  logic [BYTE_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [BYTE_W-1:0] rf_wdata,
   output logic [MODE_W-1:0] alu_mode,
   output logic [BYTE_W-1:0] alu_a,
   output logic [BYTE_W-1:0] alu_b,
   output logic [BYTE_W-1:0] alu_flags,
   input  logic [BYTE_W-1:0] alu_out,
   input  logic [BYTE_W-1:0] alu_out_flags,
   output logic [BYTE_W-1:0] flags_out,
   output logic              flags_we
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RD_LO = 3'd1;
   localparam logic [2:0] ST_EX_LO = 3'd2;
   localparam logic [2:0] ST_RD_HI = 3'd3;
   localparam logic [2:0] ST_EX_HI = 3'd4;

   logic [2:0]        state_q,     state_d;
   logic              op_dec_q,    op_dec_d;
   logic [BYTE_W-1:0] lo_addr_q,   lo_addr_d;
   logic [BYTE_W-1:0] flags_q,     flags_d;
   logic [BYTE_W-1:0] lo_res_q,    lo_res_d;
   logic [BYTE_W-1:0] lo_flags_q,  lo_flags_d;
   logic [BYTE_W-1:0] flags_out_q, flags_out_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              rf_we_q,     rf_we_d;
   logic              flags_we_q,  flags_we_d;

   logic [BYTE_W-1:0] hi_addr;
   logic [BYTE_W-1:0] lo_flags_seed;

   // The low byte always lives at the odd address of the pair.
   assign hi_addr       = lo_addr_q & 8'hFE;
   assign lo_flags_seed = flags_q | (8'h01 << FLAG_INDEX_Z);

   always_comb begin
      state_d     = state_q;
      op_dec_d    = op_dec_q;
      lo_addr_d   = lo_addr_q;
      flags_d     = flags_q;
      lo_res_d    = lo_res_q;
      lo_flags_d  = lo_flags_q;
      flags_out_d = flags_out_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_dec_d  = op_dec;
               lo_addr_d = pair_addr | 8'h01;
               flags_d   = flags_in;
               state_d   = ST_RD_LO;
            end
         end
         ST_RD_LO: state_d = ST_EX_LO;
         ST_EX_LO: begin
            lo_res_d   = alu_out;
            lo_flags_d = alu_out_flags;
            state_d    = ST_RD_HI;
         end
         ST_RD_HI: state_d = ST_EX_HI;
         ST_EX_HI: begin
            flags_out_d = alu_out_flags;
            state_d     = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      // Strobes are registered from the next state so they align with it.
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_EX_HI);
      rf_we_d    = (state_d == ST_EX_LO) || (state_d == ST_EX_HI);
      flags_we_d = (state_d == ST_EX_HI);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_dec_q    <= 1'b0;
         lo_addr_q   <= 8'h00;
         flags_q     <= 8'h00;
         lo_res_q    <= 8'h00;
         lo_flags_q  <= 8'h00;
         flags_out_q <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rf_we_q     <= 1'b0;
         flags_we_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_dec_q    <= op_dec_d;
         lo_addr_q   <= lo_addr_d;
         flags_q     <= flags_d;
         lo_res_q    <= lo_res_d;
         lo_flags_q  <= lo_flags_d;
         flags_out_q <= flags_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rf_we_q     <= rf_we_d;
         flags_we_q  <= flags_we_d;
      end
   end

   always_comb begin
      rf_addr   = 8'h00;
      alu_mode  = ALU1_NOP;
      alu_flags = 8'h00;
      case (state_q)
         ST_RD_LO: rf_addr = lo_addr_q;
         ST_EX_LO: begin
            rf_addr   = lo_addr_q;
            alu_mode  = op_dec_q ? ALU1_DECW : ALU1_INCW;
            alu_flags = lo_flags_seed;
         end
         ST_RD_HI: rf_addr = hi_addr;
         ST_EX_HI: begin
            rf_addr   = hi_addr;
            alu_mode  = upper_mode(op_dec_q, lo_res_q);
            alu_flags = lo_flags_q;
         end
         default: begin
            rf_addr   = 8'h00;
            alu_mode  = ALU1_NOP;
            alu_flags = 8'h00;
         end
      endcase
   end

   assign alu_a     = rf_rdata;
   assign alu_b     = 8'h00;
   assign rf_wdata  = alu_out;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rf_we     = rf_we_q;
   assign flags_we  = flags_we_q;
   assign flags_out = flags_out_q;

endmodule

`default_nettype wire
